// File: rtl/cenn_readout_ctrl.sv
// CeNN readout sequencer: walks cell pairs, binarizes against a button-selected threshold, writes the frame buffer.
// Optional macro POSTPROC_DEBOUNCE_EN adds a stable-count debouncer behind each button synchronizer.
module cenn_readout_ctrl #(
    parameter int unsigned width_fixed     = 15,
    parameter int unsigned width_RGB       = 8,
    parameter int unsigned N_CELLS         = 64,
    parameter int unsigned ADDR_W          = 6,
    parameter int unsigned READ_LAT        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          press_UP,
    input  logic                          press_DOWN,
    input  logic                          ready_signal,
    input  logic signed [width_fixed-1:0] out_cenn_0,
    input  logic signed [width_fixed-1:0] out_cenn_x,
    output logic [ADDR_W-1:0]             cell_addr,
    output logic                          fb_wr_en,
    input  logic                          fb_ready,
    output logic [ADDR_W-1:0]             fb_addr,
    output logic [width_RGB-1:0]          black_white_0,
    output logic [width_RGB-1:0]          black_white_x,
    output logic                          busy,
    output logic                          frame_done,
    output logic [4:0]                    led
);

    localparam int unsigned CNT_W = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_WRITE, S_DONE} state_t;

    logic [1:0] up_sync, dn_sync;
    logic       up_press_c, dn_press_c;
    logic [2:0] level, level_d;
    logic       rdy_q, rdy_prev, rdy_edge_c;

    state_t                        state, state_d;
    logic [ADDR_W-1:0]             addr, addr_d, cell_addr_d, fb_addr_d;
    logic [CNT_W-1:0]              cnt, cnt_d;
    logic signed [width_fixed-1:0] thr_c, t_active, t_active_d;
    logic [width_RGB-1:0]          bw0_d, bwx_d;

    // Two-flop synchronizers for the raw buttons and the convergence flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_sync  <= '0;
            dn_sync  <= '0;
            rdy_q    <= 1'b0;
            rdy_prev <= 1'b0;
        end else begin
            up_sync  <= {up_sync[0], press_UP};
            dn_sync  <= {dn_sync[0], press_DOWN};
            rdy_q    <= ready_signal;
            rdy_prev <= rdy_q;
        end
    end

    assign rdy_edge_c = rdy_q & ~rdy_prev;

`ifdef POSTPROC_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            up_db, dn_db, up_flip_c, dn_flip_c;
    logic [DB_W-1:0] up_cnt, dn_cnt;

    assign up_flip_c  = (up_sync[1] != up_db) && (up_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign dn_flip_c  = (dn_sync[1] != dn_db) && (dn_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    // Press event fires in the same cycle the debounced level goes high
    assign up_press_c = up_flip_c & up_sync[1];
    assign dn_press_c = dn_flip_c & dn_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_db  <= 1'b0;
            dn_db  <= 1'b0;
            up_cnt <= '0;
            dn_cnt <= '0;
        end else begin
            if (up_sync[1] == up_db) begin
                up_cnt <= '0;
            end else if (up_flip_c) begin
                up_db  <= up_sync[1];
                up_cnt <= '0;
            end else begin
                up_cnt <= up_cnt + DB_W'(1);
            end
            if (dn_sync[1] == dn_db) begin
                dn_cnt <= '0;
            end else if (dn_flip_c) begin
                dn_db  <= dn_sync[1];
                dn_cnt <= '0;
            end else begin
                dn_cnt <= dn_cnt + DB_W'(1);
            end
        end
    end
`else
    logic up_prev, dn_prev;

    assign up_press_c = up_sync[1] & ~up_prev;
    assign dn_press_c = dn_sync[1] & ~dn_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_prev <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_prev <= up_sync[1];
            dn_prev <= dn_sync[1];
        end
    end
`endif

    // Saturating threshold level; simultaneous presses cancel
    always_comb begin
        level_d = level;
        if (up_press_c && !dn_press_c && level != 3'd4) begin
            level_d = level + 3'd1;
        end else if (dn_press_c && !up_press_c && level != 3'd0) begin
            level_d = level - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 3'd2;
            led   <= 5'b00100;
        end else begin
            level <= level_d;
            led   <= 5'b00001 << level_d;
        end
    end

    assign thr_c = width_fixed'((int'(level) - 2) <<< (width_fixed - 4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            cnt           <= '0;
            t_active      <= '0;
            cell_addr     <= '0;
            fb_addr       <= '0;
            black_white_0 <= '0;
            black_white_x <= '0;
            fb_wr_en      <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_d;
            addr          <= addr_d;
            cnt           <= cnt_d;
            t_active      <= t_active_d;
            cell_addr     <= cell_addr_d;
            fb_addr       <= fb_addr_d;
            black_white_0 <= bw0_d;
            black_white_x <= bwx_d;
            fb_wr_en      <= (state_d == S_WRITE);
            busy          <= (state_d == S_ADDR) || (state_d == S_WAIT) || (state_d == S_WRITE);
            frame_done    <= (state_d == S_DONE);
        end
    end

    // Next-state logic; cell_addr is loaded on entry to ADDR so it is valid throughout ADDR/WAIT
    always_comb begin
        state_d     = state;
        addr_d      = addr;
        cnt_d       = cnt;
        t_active_d  = t_active;
        cell_addr_d = cell_addr;
        fb_addr_d   = fb_addr;
        bw0_d       = black_white_0;
        bwx_d       = black_white_x;
        case (state)
            S_IDLE: begin
                if (rdy_edge_c) begin
                    addr_d      = '0;
                    cell_addr_d = '0;
                    t_active_d  = thr_c;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = CNT_W'(READ_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bw0_d     = (out_cenn_0 >= t_active) ? {width_RGB{1'b1}} : {width_RGB{1'b0}};
                    bwx_d     = (out_cenn_x >= t_active) ? {width_RGB{1'b1}} : {width_RGB{1'b0}};
                    fb_addr_d = addr;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (fb_ready) begin
                    if (addr == ADDR_W'(N_CELLS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d      = addr + ADDR_W'(1);
                        cell_addr_d = addr + ADDR_W'(1);
                        state_d     = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cenn_readout_ctrl.sv
// Directed bench for cenn_readout_ctrl: scoreboarded frame-buffer writes, threshold levels, stalls and reset.
module tb_cenn_readout_ctrl;

    localparam int W  = 15;
    localparam int RG = 8;
    localparam int N  = 4;
    localparam int AW = 2;
    localparam int RL = 2;
    localparam int DB = 4;

    logic                clk, rst, press_UP, press_DOWN, ready_signal, fb_ready;
    logic signed [W-1:0] out_cenn_0, out_cenn_x;
    logic [AW-1:0]       cell_addr, fb_addr;
    logic                fb_wr_en, busy, frame_done;
    logic [RG-1:0]       black_white_0, black_white_x;
    logic [4:0]          led;

    logic signed [W-1:0] mem0 [N];
    logic signed [W-1:0] memx [N];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [RG-1:0] b0;
        logic [RG-1:0] bx;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;
    int exp_lv = 2;

    logic          hold_q = 1'b0;
    logic [AW-1:0] hold_a;
    logic [RG-1:0] hold_b0, hold_bx;

    cenn_readout_ctrl #(
        .width_fixed(W), .width_RGB(RG), .N_CELLS(N), .ADDR_W(AW),
        .READ_LAT(RL), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .press_UP(press_UP), .press_DOWN(press_DOWN),
        .ready_signal(ready_signal), .out_cenn_0(out_cenn_0), .out_cenn_x(out_cenn_x),
        .cell_addr(cell_addr), .fb_wr_en(fb_wr_en), .fb_ready(fb_ready), .fb_addr(fb_addr),
        .black_white_0(black_white_0), .black_white_x(black_white_x),
        .busy(busy), .frame_done(frame_done), .led(led)
    );

    assign out_cenn_0 = mem0[cell_addr];
    assign out_cenn_x = memx[cell_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RG-1:0] bin(input logic signed [W-1:0] v, input int lv);
        int t;
        t = (lv - 2) * (1 << (W - 4));
        return (int'(v) >= t) ? 8'hFF : 8'h00;
    endfunction

    task automatic set_pair(input int i, input int a, input int b);
        mem0[i] = W'(a);
        memx[i] = W'(b);
    endtask

    task automatic push_frame(input int lv);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.a  = AW'(i);
            e.b0 = bin(mem0[i], lv);
            e.bx = bin(memx[i], lv);
            sb.push_back(e);
        end
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        press_UP   = up;
        press_DOWN = dn;
        repeat (hold) tick();
        press_UP   = 1'b0;
        press_DOWN = 1'b0;
        repeat (10) tick();
    endtask

    // Runs one frame; optional stall on pair 1, mid-frame re-pulse of ready and mid-frame DOWN press
    task automatic run_frame(input logic stall, input logic repulse, input logic mid_down);
        int cyc, len, pulses, left, w0;
        logic stalled;
        w0 = n_writes;
        fb_ready = 1'b1;
        ready_signal = 1'b1;
        cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check("busy_rise", 32'(busy), 32'd1);
        len = 0; pulses = 0; left = 0; stalled = 1'b0;
        while ((busy || frame_done) && len < 200) begin
            if (frame_done) pulses++;
            len++;
            if (stall && !stalled && fb_wr_en && fb_addr == AW'(1)) begin
                left = 5;
                stalled = 1'b1;
            end
            fb_ready = (left == 0);
            if (left > 0) left--;
            if (repulse && len == 5) ready_signal = 1'b0;
            if (repulse && len == 7) ready_signal = 1'b1;
            press_DOWN = mid_down && len >= 2 && len < 12;
            tick();
        end
        press_DOWN = 1'b0;
        fb_ready = 1'b1;
        check("frame_len", 32'(len), 32'(N * (RL + 2) + 1 + (stall ? 5 : 0)));
        check("done_pulses", 32'(pulses), 32'd1);
        check("writes_per_frame", 32'(n_writes - w0), 32'(N));
        check("sb_drained", 32'(sb.size()), 32'd0);
        repeat (8) tick();
        check("idle_after_frame", 32'(busy), 32'd0);
        ready_signal = 1'b0;
        repeat (10) tick();
    endtask

    // Scoreboard monitor: checks each handshake and stability while stalled
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("stall_wr_en", 32'(fb_wr_en), 32'd1);
                check("stall_addr", 32'(fb_addr), 32'(hold_a));
                check("stall_data", 32'({black_white_0, black_white_x}), 32'({hold_b0, hold_bx}));
            end
            hold_q  = fb_wr_en && !fb_ready;
            hold_a  = fb_addr;
            hold_b0 = black_white_0;
            hold_bx = black_white_x;
            if (fb_wr_en && fb_ready) begin
                n_writes++;
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(e.a));
                    check("wr_bw0", 32'(black_white_0), 32'(e.b0));
                    check("wr_bwx", 32'(black_white_x), 32'(e.bx));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; press_UP = 1'b0; press_DOWN = 1'b0; ready_signal = 1'b0; fb_ready = 1'b1;
        for (int i = 0; i < N; i++) set_pair(i, 0, 0);
        repeat (3) tick();
        check("rst_cell_addr", 32'(cell_addr), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_ctrl", 32'({fb_wr_en, busy, frame_done}), 32'd0);
        check("rst_bw", 32'({black_white_0, black_white_x}), 32'd0);
        check("rst_led", 32'(led), 32'b00100);
        rst = 1'b0;
        repeat (3) tick();

        // Level 2, threshold 0
        set_pair(0, 1, -1); set_pair(1, -1, 1); set_pair(2, 0, -16384); set_pair(3, 16383, -1);
        push_frame(exp_lv);
        run_frame(1'b0, 1'b0, 1'b0);

        // Stall pair 1 for 5 cycles, re-pulse ready while busy
        set_pair(0, -2, 2); set_pair(1, 100, -100); set_pair(2, -16384, 16383); set_pair(3, 0, 0);
        push_frame(exp_lv);
        run_frame(1'b1, 1'b1, 1'b0);

        // Three UP presses saturate at level 4
        press(1'b1, 1'b0, 8); exp_lv = 3;
        check("led_up1", 32'(led), 32'(1) << exp_lv);
        press(1'b1, 1'b0, 8); exp_lv = 4;
        check("led_up2", 32'(led), 32'(1) << exp_lv);
        press(1'b1, 1'b0, 8);
        check("led_up_sat", 32'(led), 32'b10000);

        // Level 4 frame with DOWN pressed mid-frame: threshold stays latched
        set_pair(0, 4095, 16383); set_pair(1, 4096, 4097); set_pair(2, 2047, -4096); set_pair(3, -1, 0);
        push_frame(4);
        run_frame(1'b0, 1'b0, 1'b1);
        exp_lv = 3;
        check("led_mid_down", 32'(led), 32'(1) << exp_lv);

`ifdef POSTPROC_DEBOUNCE_EN
        press(1'b1, 1'b0, 2);
        check("led_glitch", 32'(led), 32'(1) << exp_lv);
`endif
        press(1'b1, 1'b1, 8);
        check("led_both", 32'(led), 32'(1) << exp_lv);

        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 8);
        exp_lv = 0;
        check("led_down_sat", 32'(led), 32'b00001);

        // Level 0, threshold -4096
        set_pair(0, -4096, -4095); set_pair(1, -4097, 16383); set_pair(2, -16384, -1); set_pair(3, 0, -4097);
        push_frame(exp_lv);
        run_frame(1'b0, 1'b0, 1'b0);

        // Reset mid-frame
        set_pair(0, 5, 5); set_pair(1, 5, 5); set_pair(2, 5, 5); set_pair(3, 5, 5);
        push_frame(exp_lv);
        ready_signal = 1'b1;
        repeat (9) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        ready_signal = 1'b0;
        tick();
        check("midrst_addrs", 32'({cell_addr, fb_addr}), 32'd0);
        check("midrst_ctrl", 32'({fb_wr_en, busy, frame_done}), 32'd0);
        check("midrst_bw", 32'({black_white_0, black_white_x}), 32'd0);
        check("midrst_led", 32'(led), 32'b00100);
        sb.delete();
        rst = 1'b0;
        exp_lv = 2;
        repeat (3) tick();

        // Fresh frame after reset starts at address 0 with level 2
        set_pair(0, -1, 0); set_pair(1, 0, -1); set_pair(2, 7, -7); set_pair(3, -16384, 16383);
        push_frame(exp_lv);
        run_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
